// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the operand forwarding unit.
//   fwd_sel_e   : per-lane operand source (register file, MEM/WB, EX/MEM)
//   fsm_state_e : load-use stall controller states
//   FWD_SEL_W   : width of one lane's select field
// ---------------------------------------------------------------------------
package fwd_pkg;

  localparam int FWD_SEL_W = 2;

  // 2'b11 is deliberately left unused and is never driven.
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fwd_lane.sv
// ---------------------------------------------------------------------------
// fwd_lane
// One source-operand lane: compares the lane's EX-stage source address with
// the EX/MEM and MEM/WB destinations and muxes the freshest value.
// Purely combinational.
//   rs                 : EX-stage source address of this lane
//   rf_data            : register-file operand for this lane
//   ex_mem_*           : EX/MEM writeback candidate (highest priority)
//   mem_wb_*           : MEM/WB writeback candidate
//   sel                : chosen source (fwd_sel_e encoding)
//   data               : forwarded operand
// ---------------------------------------------------------------------------
module fwd_lane
  import fwd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0]    rs,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [REG_AW-1:0]    ex_mem_rd,
  input  logic                 ex_mem_reg_write,
  input  logic [XLEN-1:0]      ex_mem_result,
  input  logic [REG_AW-1:0]    mem_wb_rd,
  input  logic                 mem_wb_reg_write,
  input  logic [XLEN-1:0]      mem_wb_wdata,
  output logic [FWD_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      data
);

  logic     ex_hit;
  logic     wb_hit;
  fwd_sel_e sel_e;

  // Register 0 is hardwired to zero, so a write to it is never forwarded.
  // That also makes rs==0 always resolve to the register file.
  assign ex_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel_e = FWD_RF;
    data  = rf_data;
    if (ex_hit) begin
      sel_e = FWD_MEM;
      data  = ex_mem_result;
    end else if (wb_hit) begin
      sel_e = FWD_WB;
      data  = mem_wb_wdata;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/operand_forward_unit.sv
// ---------------------------------------------------------------------------
// operand_forward_unit
// Operand forwarding and load-use hazard control for an in-order pipeline.
//
// Forwarding (combinational, zero latency): each of NUM_SRC lanes picks its
// EX-stage operand from EX/MEM, MEM/WB or the register file.
// Hazard control: a load in EX whose destination is read by the decode-stage
// instruction stalls PC and IF/ID and bubbles ID/EX for exactly LOAD_LAT
// cycles. flush_in overrides any stall.
//
// Ports
//   clk, rst_n          : rising-edge clock, async active-low reset
//   if_id_rs[_used]     : decode-stage source addresses / lane valid
//   id_ex_rs[_data]     : EX-stage source addresses / register-file operands
//   id_ex_rd, id_ex_mem_read : EX-stage destination / is-load
//   ex_mem_*, mem_wb_*  : writeback candidates for forwarding
//   flush_in            : pipeline flush (branch redirect)
//   fwd_sel             : per-lane select, 2 bits per lane
//   alu_src_data        : forwarded operands, XLEN per lane
//   pc_write_en, if_id_write_en, id_ex_flush : stall controls
//   stall_active        : controller is in STALL
//   fwd_event_cnt, stall_cycle_cnt : saturating statistics counters,
//                         present only when OPERAND_FWD_STATS_EN is defined
// ---------------------------------------------------------------------------
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]    if_id_rs,
  input  logic [NUM_SRC-1:0]           if_id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]    id_ex_rs,
  input  logic [NUM_SRC*XLEN-1:0]      id_ex_rs_data,
  input  logic [REG_AW-1:0]            id_ex_rd,
  input  logic                         id_ex_mem_read,
  input  logic [REG_AW-1:0]            ex_mem_rd,
  input  logic                         ex_mem_reg_write,
  input  logic [XLEN-1:0]              ex_mem_result,
  input  logic [REG_AW-1:0]            mem_wb_rd,
  input  logic                         mem_wb_reg_write,
  input  logic [XLEN-1:0]              mem_wb_wdata,
  input  logic                         flush_in,
  output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]      alu_src_data,
  output logic                         pc_write_en,
  output logic                         if_id_write_en,
  output logic                         id_ex_flush,
`ifdef OPERAND_FWD_STATS_EN
  output logic [31:0]                  fwd_event_cnt,
  output logic [31:0]                  stall_cycle_cnt,
`endif
  output logic                         stall_active
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  // -------------------------------------------------------------------------
  // Forwarding lanes
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_lane #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
    ) u_lane (
      .rs               (id_ex_rs[i*REG_AW +: REG_AW]),
      .rf_data          (id_ex_rs_data[i*XLEN +: XLEN]),
      .ex_mem_rd        (ex_mem_rd),
      .ex_mem_reg_write (ex_mem_reg_write),
      .ex_mem_result    (ex_mem_result),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_reg_write (mem_wb_reg_write),
      .mem_wb_wdata     (mem_wb_wdata),
      .sel              (fwd_sel[i*FWD_SEL_W +: FWD_SEL_W]),
      .data             (alu_src_data[i*XLEN +: XLEN])
    );
  end

  // -------------------------------------------------------------------------
  // Load-use hazard detection on the decode-stage sources
  // -------------------------------------------------------------------------
  logic hazard;

  always_comb begin
    hazard = 1'b0;
    if (id_ex_mem_read && (id_ex_rd != '0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (if_id_rs_used[i] && (if_id_rs[i*REG_AW +: REG_AW] == id_ex_rd))
          hazard = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stall controller. The hazard cycle itself is the first stall cycle and is
  // spent in RUN; STALL covers the remaining LOAD_LAT-1 cycles, so a
  // LOAD_LAT of 1 never leaves RUN. The bubble pushed into ID/EX carries
  // id_ex_mem_read=0, so the same load cannot re-trigger on return to RUN.
  // -------------------------------------------------------------------------
  fsm_state_e       state;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else if (flush_in) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state     <= STALL;
            stall_cnt <= CNT_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt - 1'b1;
          if (stall_cnt == CNT_W'(1))
            state <= RUN;
        end
        default: begin
          state     <= RUN;
          stall_cnt <= '0;
        end
      endcase
    end
  end

  // Stall controls must react in the hazard cycle itself, so they are decoded
  // from the registered state plus the live hazard rather than registered.
  logic stall_now;

  assign stall_now      = !flush_in && ((state == STALL) || hazard);
  assign pc_write_en    = !stall_now;
  assign if_id_write_en = !stall_now;
  assign id_ex_flush    = stall_now;
  assign stall_active   = (state == STALL);

`ifdef OPERAND_FWD_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating statistics counters
  // -------------------------------------------------------------------------
  logic any_fwd;

  always_comb begin
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_sel[i*FWD_SEL_W +: FWD_SEL_W] != FWD_RF)
        any_fwd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_event_cnt   <= '0;
      stall_cycle_cnt <= '0;
    end else begin
      if (any_fwd && !(&fwd_event_cnt))
        fwd_event_cnt <= fwd_event_cnt + 32'd1;
      if (!pc_write_en && !(&stall_cycle_cnt))
        stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/operand_forward_unit.md
OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source-operand lanes (1..4).
REQ-003 SHALL have parameter REG_AW, default 5, register-address width.
REQ-004 SHALL have parameter LOAD_LAT, default 1, load-use stall length in cycles (1..4).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have the following ports:
- if_id_rs, input, NUM_SRC*REG_AW, decode-stage source addresses.
- if_id_rs_used, input, NUM_SRC, per-lane source valid.
- id_ex_rs, input, NUM_SRC*REG_AW, EX-stage source addresses.
- id_ex_rs_data, input, NUM_SRC*XLEN, register-file operands.
- id_ex_rd, input, REG_AW, EX-stage destination.
- id_ex_mem_read, input, 1, EX-stage instruction is a load.
- ex_mem_rd, input, REG_AW; ex_mem_reg_write, input, 1; ex_mem_result, input, XLEN.
- mem_wb_rd, input, REG_AW; mem_wb_reg_write, input, 1; mem_wb_wdata, input, XLEN.
- flush_in, input, 1, pipeline flush (branch redirect).
- fwd_sel, output, NUM_SRC*2, per-lane select.
- alu_src_data, output, NUM_SRC*XLEN, forwarded operands.
- pc_write_en, output, 1; if_id_write_en, output, 1; id_ex_flush, output, 1.
- stall_active, output, 1, FSM in STALL.

Function
REQ-007 SHALL encode fwd_sel per lane as 00 register file, 01 MEM/WB, 10 EX/MEM; 11 SHALL never be driven.
REQ-008 SHALL select 10 when ex_mem_reg_write=1, ex_mem_rd!=0 and ex_mem_rd==lane rs.
REQ-009 SHALL otherwise select 01 when mem_wb_reg_write=1, mem_wb_rd!=0 and mem_wb_rd==lane rs.
REQ-010 SHALL otherwise select 00; lane rs==0 SHALL always yield 00.
REQ-011 SHALL drive fwd_sel and alu_src_data combinationally, with zero-cycle latency.
REQ-012 SHALL detect a load-use hazard when id_ex_mem_read=1, id_ex_rd!=0, and any lane has if_id_rs_used=1 with if_id_rs==id_ex_rd.
REQ-013 SHALL implement the FSM states RUN and STALL, with a down-counter stall_cnt of width clog2(LOAD_LAT+1).
REQ-014 SHALL, in RUN with a hazard: drive pc_write_en=0, if_id_write_en=0, id_ex_flush=1 in that same cycle; when LOAD_LAT>1, go to STALL with stall_cnt=LOAD_LAT-1.
REQ-015 SHALL, in STALL: hold pc_write_en=0, if_id_write_en=0, id_ex_flush=1; decrement stall_cnt each cycle; return to RUN in the cycle after stall_cnt==1 is seen.
REQ-016 SHALL make the total stall exactly LOAD_LAT cycles per hazard.
REQ-017 SHALL, in RUN without a hazard, drive pc_write_en=1, if_id_write_en=1, id_ex_flush=0.
REQ-018 SHALL, when flush_in=1: force the next state to RUN, clear stall_cnt, and suppress hazard stall outputs that cycle. flush_in wins over a simultaneous hazard.
REQ-019 SHALL NOT re-trigger a hazard from the bubble it inserts, since a bubble carries id_ex_mem_read=0.
REQ-020 SHALL drive stall_active=1 only in STALL.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-stall: FSM=RUN, stall_cnt=0, pc_write_en=1, if_id_write_en=1, id_ex_flush=0, stall_active=0, stats counters=0.
REQ-022 SHALL leave combinational forwarding outputs following their inputs during reset.

Configuration
REQ-023 SHALL, with macro OPERAND_FWD_STATS_EN defined, add 32-bit outputs fwd_event_cnt (+1 per cycle any lane selects non-00) and stall_cycle_cnt (+1 per cycle pc_write_en=0). Both counters SHALL saturate at all-ones.
REQ-024 SHALL, without OPERAND_FWD_STATS_EN, have no such ports and no counter logic.

Structure
REQ-025 SHALL define in package fwd_pkg: the fwd_sel_e enum (FWD_RF, FWD_WB, FWD_MEM), the fsm_state_e enum (RUN, STALL), and the constant FWD_SEL_W=2.
REQ-026 SHALL implement per-lane compare and mux in sub-module fwd_lane, instantiated NUM_SRC times via generate; the FSM SHALL stay in the top level.

Verification
REQ-027 SHALL cover: ex_mem_rd=5, ex_mem_reg_write=1, mem_wb_rd=5, mem_wb_reg_write=1, lane0 rs=5 -> fwd_sel lane0=10, alu_src_data=ex_mem_result.
REQ-028 SHALL cover: ex_mem_rd=0, ex_mem_reg_write=1, lane1 rs=0 -> fwd_sel lane1=00.
REQ-029 SHALL cover: LOAD_LAT=3, id_ex_mem_read=1, id_ex_rd=7, if_id_rs lane1=7, used=1 -> pc_write_en=0 for exactly 3 cycles, then 1.
REQ-030 SHALL cover: LOAD_LAT=3, hazard, then flush_in=1 in the 2nd stall cycle -> RUN next cycle, pc_write_en=1.
REQ-031 SHALL cover: rst_n asserted mid-stall -> outputs immediately at REQ-021 values.
REQ-032 SHALL cover, with OPERAND_FWD_STATS_EN: 2 forward cycles plus 1 stall -> fwd_event_cnt=2, stall_cycle_cnt=1.
